// File: rtl/freq_meter_gated.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_gated
// Brief    : Gated frequency meter; counts synchronised sig_in rising edges over
//            a GATE_CYCLES window and publishes edge_count << SCALE_SHIFT.
//            Define PEAK_HOLD_EN to add the freq_peak / peak_clr peak-hold path.
// Revision : 1.0  initial release
// ============================================================================
module freq_meter_gated #(
  parameter int CNT_W       = 24,
  parameter int GATE_CYCLES = 25_000_000,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sig_in,
  input  logic                         start,
  input  logic                         cont,
  input  logic                         abort,
`ifdef PEAK_HOLD_EN
  input  logic                         peak_clr,
  output logic [CNT_W+SCALE_SHIFT-1:0] freq_peak,
`endif
  output logic                         busy,
  output logic [CNT_W+SCALE_SHIFT-1:0] freq_out,
  output logic                         freq_valid,
  output logic                         ovf
);

  localparam int                OUT_W     = CNT_W + SCALE_SHIFT;
  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t             state;
  logic               s1, s2, s3;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic [CNT_W-1:0]   final_cnt;
  logic               final_ovf;
  logic               pub_pend;
  logic               rise;
  logic [CNT_W:0]     sum;
  logic [CNT_W-1:0]   edge_next;
  logic [OUT_W-1:0]   scaled;

  assign rise      = s2 & ~s3;
  assign sum       = {1'b0, edge_cnt} + {{CNT_W{1'b0}}, rise};
  assign edge_next = sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  assign scaled    = OUT_W'(final_cnt) << SCALE_SHIFT;

  // Reset-to-0 synchroniser: a high sig_in at release looks like a late edge, harmless in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      final_cnt  <= '0;
      final_ovf  <= 1'b0;
      pub_pend   <= 1'b0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      // A result captured in the last gate cycle is published one cycle later.
      freq_valid <= pub_pend;
      pub_pend   <= 1'b0;
      if (pub_pend) begin
        freq_out <= scaled;
        ovf      <= final_ovf;
      end
      if (abort) begin
        state    <= IDLE;
        busy     <= 1'b0;
        gate_cnt <= '0;
        edge_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            if (start || cont) begin
              state <= MEASURE;
              busy  <= 1'b1;
            end
          end
          MEASURE: begin
            if (gate_cnt == GATE_LAST) begin
              final_cnt <= edge_next;
              final_ovf <= (edge_next == CNT_MAX);
              pub_pend  <= 1'b1;
              gate_cnt  <= '0;
              edge_cnt  <= '0;
              if (!cont) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              gate_cnt <= gate_cnt + 1'b1;
              edge_cnt <= edge_next;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef PEAK_HOLD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freq_peak <= '0;
    end else if (peak_clr) begin
      freq_peak <= pub_pend ? scaled : '0;
    end else if (pub_pend && (scaled > freq_peak)) begin
      freq_peak <= scaled;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_gated.sv
`default_nettype none
// ============================================================================
// Module   : tb_freq_meter_gated
// Brief    : Window-level model bench for freq_meter_gated (CNT_W 8 and 5 copies).
// Revision : 1.0  initial release
// ============================================================================
module tb_freq_meter_gated;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic       busy8, valid8, ovf8, busy5, valid5, ovf5;
  logic [8:0] out8;
  logic [5:0] out5;
`ifdef PEAK_HOLD_EN
  logic       peak_clr = 1'b0;
  logic [8:0] pk8;
  logic [5:0] pk5;
`endif

  int   checks = 0;
  int   errors = 0;
  int   sig_period = 0;
  logic sig_static = 1'b0;
  int   busy_cnt = 0;

  freq_meter_gated #(.CNT_W(8), .GATE_CYCLES(G), .SCALE_SHIFT(1)) u_dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont), .abort(abort),
`ifdef PEAK_HOLD_EN
    .peak_clr(peak_clr), .freq_peak(pk8),
`endif
    .busy(busy8), .freq_out(out8), .freq_valid(valid8), .ovf(ovf8)
  );

  freq_meter_gated #(.CNT_W(5), .GATE_CYCLES(G), .SCALE_SHIFT(1)) u_dut5 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont), .abort(abort),
`ifdef PEAK_HOLD_EN
    .peak_clr(peak_clr), .freq_peak(pk5),
`endif
    .busy(busy5), .freq_out(out5), .freq_valid(valid5), .ovf(ovf5)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name, input int limit, output int waited);
    waited = 0;
    do begin
      step(1);
      waited++;
    end while (!valid8 && waited < limit);
    if (!valid8) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual %0d cycles required freq_valid", name, waited);
    end
  endtask

  // Square-wave source: high for the first half of each period, or static level when period is 0.
  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (sig_period == 0) begin
        sig_in = sig_static;
      end else begin
        ph     = ph % sig_period;
        sig_in = (ph < sig_period / 2);
        ph     = ph + 1;
      end
    end
  end

  // Window model: a window opened at edge ws counts edges whose synchronised rise lands
  // in edges ws+1..ws+G, i.e. sampled transitions at indices ws-1..ws+G-2.
  bit samp [0:16383];
  int cyc = 0;
  bit m_meas = 0;
  int ws = 0;
  int pub_at = -1;
  int pub_cnt = 0;
  bit e_valid = 0, e_busy = 0, e_ovf8 = 0, e_ovf5 = 0;
  int e_out8 = 0, e_out5 = 0;
  int e_pk8 = 0, e_pk5 = 0;

  function automatic int count_rises(int lo, int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++)
      if (j >= 1 && samp[j] && !samp[j-1]) n++;
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (cyc < 16384) samp[cyc] = rst ? sig_in : 1'b0;
      if (!rst) begin
        m_meas = 0; pub_at = -1; e_valid = 0;
        e_out8 = 0; e_out5 = 0; e_ovf8 = 0; e_ovf5 = 0; e_pk8 = 0; e_pk5 = 0;
      end else begin
        e_valid = (pub_at == cyc);
        if (e_valid) begin
          e_out8 = ((pub_cnt > 255) ? 255 : pub_cnt) * 2;
          e_out5 = ((pub_cnt > 31) ? 31 : pub_cnt) * 2;
          e_ovf8 = (pub_cnt >= 255);
          e_ovf5 = (pub_cnt >= 31);
        end
`ifdef PEAK_HOLD_EN
        if (peak_clr) begin
          e_pk8 = e_valid ? e_out8 : 0;
          e_pk5 = e_valid ? e_out5 : 0;
        end else if (e_valid) begin
          if (e_out8 > e_pk8) e_pk8 = e_out8;
          if (e_out5 > e_pk5) e_pk5 = e_out5;
        end
`endif
        if (abort) begin
          m_meas = 0;
        end else if (!m_meas) begin
          if (start || cont) begin
            m_meas = 1;
            ws     = cyc;
          end
        end else if (cyc == ws + G) begin
          pub_cnt = count_rises(ws - 1, ws + G - 2);
          pub_at  = cyc + 1;
          if (cont) ws = cyc;
          else m_meas = 0;
        end
      end
      e_busy = m_meas;
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_valid", {31'd0, valid8}, 32'd0);
        chk("rst_out", {23'd0, out8}, 32'd0);
        chk("rst_ovf", {31'd0, ovf8}, 32'd0);
      end else begin
        chk("busy8", {31'd0, busy8}, {31'd0, e_busy});
        chk("valid8", {31'd0, valid8}, {31'd0, e_valid});
        chk("out8", {23'd0, out8}, e_out8);
        chk("ovf8", {31'd0, ovf8}, {31'd0, e_ovf8});
        chk("busy5", {31'd0, busy5}, {31'd0, e_busy});
        chk("valid5", {31'd0, valid5}, {31'd0, e_valid});
        chk("out5", {26'd0, out5}, e_out5);
        chk("ovf5", {31'd0, ovf5}, {31'd0, e_ovf5});
`ifdef PEAK_HOLD_EN
        chk("peak8", {23'd0, pk8}, e_pk8);
        chk("peak5", {26'd0, pk5}, e_pk5);
`endif
      end
      if (busy8) busy_cnt++;
    end
  end

  initial begin
    int lat;
    int b0;
    int nv;
    rst = 1'b0;
    step(3);
    chk("reset_out", {23'd0, out8}, 32'd0);
    chk("reset_valid", {31'd0, valid8}, 32'd0);
    chk("reset_busy", {31'd0, busy8}, 32'd0);
    rst = 1'b1;
    sig_period = 10;
    step(12);

    // single shot, period 10
    b0 = busy_cnt;
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("ss", 300, lat);
    chk("ss_latency", lat, 101);
    chk("ss_freq", {23'd0, out8}, 32'd20);
    chk("ss_model", e_out8, 32'd20);
    chk("ss_ovf", {31'd0, ovf8}, 32'd0);
    chk("ss_busy_cycles", busy_cnt - b0, 100);
    step(1);
    chk("ss_pulse", {31'd0, valid8}, 32'd0);
    step(20);

    // continuous, period 4
    sig_period = 4;
    step(12);
    cont = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_valid("cont", 300, lat);
      if (k > 0) chk("cont_interval", lat, 100);
      chk("cont_freq_range", {31'd0, (out8 >= 9'd48 && out8 <= 9'd52)}, 32'd1);
    end
    cont = 1'b0;
    wait_valid("cont_tail", 300, lat);
    chk("cont_tail_interval", lat, 100);
    step(3);
    chk("cont_idle", {31'd0, busy8}, 32'd0);
    step(20);

    // saturation with CNT_W=5, then recovery
    sig_period = 2;
    step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("sat", 300, lat);
    chk("sat_out5", {26'd0, out5}, 32'd62);
    chk("sat_ovf5", {31'd0, ovf5}, 32'd1);
    chk("sat_out8", {23'd0, out8}, 32'd100);
    chk("sat_ovf8", {31'd0, ovf8}, 32'd0);
    sig_period = 10;
    step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("unsat", 300, lat);
    chk("unsat_out5", {26'd0, out5}, 32'd20);
    chk("unsat_ovf5", {31'd0, ovf5}, 32'd0);

    // abort mid-window, then abort with start
    step(5);
    start = 1'b1; step(1); start = 1'b0;
    step(49);
    abort = 1'b1; step(1); abort = 1'b0;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    nv = 0;
    for (int i = 0; i < 150; i++) begin
      step(1);
      if (valid8) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_hold", {23'd0, out8}, 32'd20);
    start = 1'b1; abort = 1'b1; step(1); start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {31'd0, busy8}, 32'd0);
    step(3);
    chk("abort_start_idle2", {31'd0, busy8}, 32'd0);

    // reset mid-window, then static-high input
    start = 1'b1; step(1); start = 1'b0;
    step(30);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy8}, 32'd0);
    chk("arst_out", {23'd0, out8}, 32'd0);
    sig_period = 0;
    sig_static = 1'b1;
    step(3);
    rst = 1'b1;
    step(10);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("static", 300, lat);
    chk("static_high", {23'd0, out8}, 32'd0);
    chk("static_ovf", {31'd0, ovf8}, 32'd0);

`ifdef PEAK_HOLD_EN
    sig_period = 10; step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("pk1", 300, lat); step(1);
    chk("peak_20", {23'd0, pk8}, 32'd20);
    sig_period = 4; step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("pk2", 300, lat); step(1);
    chk("peak_50", {23'd0, pk8}, 32'd50);
    sig_period = 7; step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("pk3", 300, lat); step(1);
    chk("peak_hold", {23'd0, pk8}, 32'd50);
    peak_clr = 1'b1; step(1); peak_clr = 1'b0;
    chk("peak_clr", {23'd0, pk8}, 32'd0);
    sig_period = 20; step(12);
    start = 1'b1; step(1); start = 1'b0;
    wait_valid("pk4", 300, lat); step(1);
    chk("peak_10", {23'd0, pk8}, 32'd10);
`endif

    step(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
